cpu_control_unit: RTL

- Hardwired sequencer for the 8-bit datapath: drives register file (R1–R4), address register file (PC/AR/SP), IR, ALU, memory strobes and source muxes.
- Consumes the IR output and ALU flags.
- Runs fetch-low, fetch-high, execute, optional second execute; halts on HALT.

---
 rtl/cpu_control_unit_if.sv | 42 ++++
 rtl/cpu_control_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit_if.sv
// Control bundle between the hardwired sequencer and the 8-bit datapath.
// The sequencer drives through 'master'; the datapath side uses 'slave'.
interface cpu_control_unit_if;
    logic [15:0] IRout;
    logic [3:0]  ALU_Flag;
    logic [1:0]  RF_OutASel;
    logic [1:0]  RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_En;
    logic [1:0]  IR_FunSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        Mem_CS;
    logic        Mem_WR;
    logic [3:0]  Flags;
    logic        Halted;
    // Byte presented on the IR[7:0] mux input: PC_RESET during INIT, IR[7:0] otherwise.
    logic [7:0]  Imm_Out;

    modport master (
        input  IRout, ALU_Flag,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_En, IR_FunSel, ALU_FunSel, MuxASel, MuxBSel,
               Mem_CS, Mem_WR, Flags, Halted, Imm_Out
    );

    modport slave (
        output IRout, ALU_Flag,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_En, IR_FunSel, ALU_FunSel, MuxASel, MuxBSel,
               Mem_CS, Mem_WR, Flags, Halted, Imm_Out
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Hardwired sequencer: INIT, two-byte fetch, one or two execute cycles, HALT.
// All control outputs are decoded combinationally from the current state and IR.
module cpu_control_unit #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    cpu_control_unit_if.master     io_ctl,
    output logic [2:0]             o_state
);
    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_F_LO = 3'd1,
        S_F_HI = 3'd2,
        S_EX1  = 3'd3,
        S_EX2  = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flags;
    logic        w_flags_we;
    logic [3:0]  w_op;
    logic [1:0]  w_dst;
    logic [1:0]  w_src;
    logic [3:0]  w_dst_en;

    assign w_op     = io_ctl.IRout[15:12];
    assign w_dst    = io_ctl.IRout[11:10];
    assign w_src    = io_ctl.IRout[9:8];
    assign w_dst_en = ~(4'b0001 << w_dst);

    assign o_state        = r_state;
    assign io_ctl.Flags   = r_flags;
    assign io_ctl.Halted  = (r_state == S_HALT);
    assign io_ctl.Imm_Out = (r_state == S_INIT) ? PC_RESET : io_ctl.IRout[7:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_INIT;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_flags_we) begin
                r_flags <= io_ctl.ALU_Flag;
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        w_flags_we         = 1'b0;
        io_ctl.RF_OutASel  = 2'd0;
        io_ctl.RF_OutBSel  = 2'd0;
        io_ctl.RF_FunSel   = 2'd0;
        io_ctl.RF_RegSel   = 4'b1111;
        io_ctl.ARF_OutCSel = 2'd0;
        io_ctl.ARF_OutDSel = 2'd0;
        io_ctl.ARF_FunSel  = 2'd0;
        io_ctl.ARF_RegSel  = 4'b1111;
        io_ctl.IR_LH       = 1'b0;
        io_ctl.IR_En       = 1'b0;
        io_ctl.IR_FunSel   = 2'd0;
        io_ctl.ALU_FunSel  = 4'b0000;
        io_ctl.MuxASel     = 2'd0;
        io_ctl.MuxBSel     = 2'd0;
        io_ctl.Mem_CS      = 1'b1;
        io_ctl.Mem_WR      = 1'b0;

        case (r_state)
            S_INIT: begin
                io_ctl.MuxBSel    = 2'd2;
                io_ctl.ARF_FunSel = 2'd2;
                io_ctl.ARF_RegSel = 4'b1110;
                w_next            = S_F_LO;
            end
            S_F_LO, S_F_HI: begin
                // Memory at PC goes into the IR byte picked by IR_LH while PC steps.
                io_ctl.ARF_OutDSel = 2'd0;
                io_ctl.Mem_CS      = 1'b0;
                io_ctl.IR_En       = 1'b1;
                io_ctl.IR_FunSel   = 2'd2;
                io_ctl.IR_LH       = (r_state == S_F_HI);
                io_ctl.ARF_FunSel  = 2'd1;
                io_ctl.ARF_RegSel  = 4'b1110;
                w_next             = (r_state == S_F_LO) ? S_F_HI : S_EX1;
            end
            S_EX1: begin
                w_next = S_F_LO;
                case (w_op)
                    4'h0: begin
                        io_ctl.MuxASel   = 2'd2;
                        io_ctl.RF_FunSel = 2'd2;
                        io_ctl.RF_RegSel = w_dst_en;
                    end
                    4'h1, 4'h2: begin
                        io_ctl.MuxBSel    = 2'd2;
                        io_ctl.ARF_FunSel = 2'd2;
                        io_ctl.ARF_RegSel = 4'b1101;
                        w_next            = S_EX2;
                    end
                    4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        io_ctl.RF_OutASel = w_dst;
                        io_ctl.RF_OutBSel = w_src;
                        io_ctl.MuxASel    = 2'd0;
                        io_ctl.RF_FunSel  = 2'd2;
                        io_ctl.RF_RegSel  = w_dst_en;
                        w_flags_we        = 1'b1;
                    end
                    4'h8, 4'h9, 4'hA: begin
                        io_ctl.RF_OutASel = w_src;
                        io_ctl.MuxASel    = 2'd0;
                        io_ctl.RF_FunSel  = 2'd2;
                        io_ctl.RF_RegSel  = w_dst_en;
                        w_flags_we        = 1'b1;
                    end
                    4'hB: begin
                        io_ctl.RF_FunSel = 2'd1;
                        io_ctl.RF_RegSel = w_dst_en;
                    end
                    4'hC: begin
                        io_ctl.RF_FunSel = 2'd0;
                        io_ctl.RF_RegSel = w_dst_en;
                    end
                    4'hD, 4'hE: begin
                        // BEQ tests the latched Z flag, never the live ALU flags.
                        if (w_op == 4'hD || r_flags[0]) begin
                            io_ctl.MuxBSel    = 2'd2;
                            io_ctl.ARF_FunSel = 2'd2;
                            io_ctl.ARF_RegSel = 4'b1110;
                        end
                    end
                    4'hF: begin
                        w_next = S_HALT;
                    end
                endcase
                case (w_op)
                    4'h3:    io_ctl.ALU_FunSel = 4'b0100;
                    4'h4:    io_ctl.ALU_FunSel = 4'b0110;
                    4'h5:    io_ctl.ALU_FunSel = 4'b0111;
                    4'h6:    io_ctl.ALU_FunSel = 4'b1000;
                    4'h7:    io_ctl.ALU_FunSel = 4'b1001;
                    4'h8:    io_ctl.ALU_FunSel = 4'b0010;
                    4'h9:    io_ctl.ALU_FunSel = 4'b1010;
                    4'hA:    io_ctl.ALU_FunSel = 4'b1011;
                    default: io_ctl.ALU_FunSel = 4'b0000;
                endcase
            end
            S_EX2: begin
                io_ctl.ARF_OutDSel = 2'd2;
                io_ctl.Mem_CS      = 1'b0;
                if (w_op == 4'h1) begin
                    io_ctl.MuxASel   = 2'd1;
                    io_ctl.RF_FunSel = 2'd2;
                    io_ctl.RF_RegSel = w_dst_en;
                end else begin
                    io_ctl.RF_OutASel = w_src;
                    io_ctl.ALU_FunSel = 4'b0000;
                    io_ctl.Mem_WR     = 1'b1;
                end
                w_next = S_F_LO;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end
endmodule
